// File: rtl/spi_slave_rhs2116.sv
// SPI mode-0 slave for RHS2116-style command/response frames, single clk_spi domain.
// Define SPI_SLAVE_SYNC_EN to add 2-flop input synchronizers (then clk_spi must be >= 8x SCLK).
module spi_slave_rhs2116 #(
  parameter int unsigned FRAME_BITS = 32,
  parameter logic        IDLE_MISO  = 1'b0
) (
  input  logic                  clk_spi,
  input  logic                  rst_n,
  input  logic                  cs_n,
  input  logic                  sclk,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [FRAME_BITS-1:0] tx_data,
  input  logic                  tx_load,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  // state    | meaning
  // ST_IDLE  | waiting for a cs_n fall, miso parked at IDLE_MISO
  // ST_SHIFT | frame in progress, sclk edges shift rx/tx
  // ST_DONE  | one cycle after cs_n rise: publish rx word or flag error
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

  logic cs_in, sclk_in, mosi_in;

`ifdef SPI_SLAVE_SYNC_EN
  logic [1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;

  // cs syncs reset low so a cs_n already low at reset release is not a fall
  always_ff @(posedge clk_spi or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q   <= 2'b00;
      sclk_sync_q <= 2'b00;
      mosi_sync_q <= 2'b00;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], cs_n};
      sclk_sync_q <= {sclk_sync_q[0], sclk};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
    end
  end

  assign cs_in   = cs_sync_q[1];
  assign sclk_in = sclk_sync_q[1];
  assign mosi_in = mosi_sync_q[1];
`else
  assign cs_in   = cs_n;
  assign sclk_in = sclk;
  assign mosi_in = mosi;
`endif

  logic cs_q, sclk_q, mosi_q;

  // cs_q resets low: after reset only a fresh high-then-low on cs_n starts a frame
  always_ff @(posedge clk_spi or negedge rst_n) begin
    if (!rst_n) begin
      cs_q   <= 1'b0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
    end else begin
      cs_q   <= cs_in;
      sclk_q <= sclk_in;
      mosi_q <= mosi_in;
    end
  end

  logic cs_fall, cs_rise, sclk_rise, sclk_fall;

  assign cs_fall   = cs_q & ~cs_in;
  assign cs_rise   = ~cs_q & cs_in;
  assign sclk_rise = ~sclk_q & sclk_in;
  assign sclk_fall = sclk_q & ~sclk_in;

  state_t                state_q, state_d;
  logic [FRAME_BITS-1:0] shadow_q, shadow_d;
  logic                  loaded_q, loaded_d;
  logic [FRAME_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [FRAME_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  miso_q, miso_d;
  logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  tx_underrun_q, tx_underrun_d;

  always_ff @(posedge clk_spi or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      shadow_q      <= '0;
      loaded_q      <= 1'b0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      cnt_q         <= '0;
      miso_q        <= IDLE_MISO;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      loaded_q      <= loaded_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      cnt_q         <= cnt_d;
      miso_q        <= miso_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    loaded_d      = loaded_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    cnt_d         = cnt_q;
    miso_d        = miso_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    frame_err_d   = 1'b0;
    tx_underrun_d = 1'b0;

    if (tx_load) begin
      shadow_d = tx_data;
      loaded_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        miso_d = IDLE_MISO;
        if (cs_fall) begin
          state_d       = ST_SHIFT;
          // a load coinciding with the cs fall belongs to this frame
          tx_shift_d    = tx_load ? tx_data : shadow_q;
          miso_d        = tx_shift_d[FRAME_BITS-1];
          cnt_d         = '0;
          loaded_d      = 1'b0;
          tx_underrun_d = ~tx_load & ~loaded_q;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_d = ST_DONE;
          miso_d  = IDLE_MISO;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[FRAME_BITS-2:0], mosi_q};
          if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (sclk_fall) begin
          tx_shift_d = tx_shift_q << 1;
          miso_d     = tx_shift_q[FRAME_BITS-2];
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        miso_d  = IDLE_MISO;
        if (cnt_q == CNT_FULL) begin
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy        = (state_q == ST_SHIFT);
  assign miso_oe     = busy;
  assign miso        = miso_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave_rhs2116.sv
// Directed bench for spi_slave_rhs2116: bench-side SPI master plus a frame-level model
// of the tx shadow / underrun / rx publish rules, checked by one per-cycle compare process.
`timescale 1ns/1ps
module tb_spi_slave_rhs2116;

  localparam int   FB       = 32;
  localparam logic IDLE_LVL = 1'b0;
`ifdef SPI_SLAVE_SYNC_EN
  localparam int SC = 4;
`else
  localparam int SC = 2;
`endif

  logic clk_spi = 1'b0;
  always #8 clk_spi = ~clk_spi;

  logic          rst_n, cs_n, sclk, mosi, miso, miso_oe;
  logic [FB-1:0] tx_data, rx_data;
  logic          tx_load, rx_valid, frame_err, tx_underrun, busy;

  spi_slave_rhs2116 #(.FRAME_BITS(FB), .IDLE_MISO(IDLE_LVL)) dut (
    .clk_spi(clk_spi), .rst_n(rst_n), .cs_n(cs_n), .sclk(sclk), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .tx_underrun(tx_underrun), .busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;

  // model state
  logic [31:0] mdl_shadow, mdl_rx_hold, mdl_rx_word;
  bit          mdl_loaded, mdl_live;

  int n_rv, n_fe, n_ur, tot_ur;
  int cs_hi_cnt, cs_lo_cnt;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk_spi) begin
    if (!rst_n) begin
      cs_hi_cnt = 0;
      cs_lo_cnt = 0;
    end else begin
      if (cs_n) begin
        cs_hi_cnt++;
        cs_lo_cnt = 0;
      end else begin
        cs_lo_cnt++;
        cs_hi_cnt = 0;
      end
      if (rx_valid) begin
        n_rv++;
        chk("rx_data_at_valid", 64'(rx_data), 64'(mdl_rx_word));
      end
      if (frame_err) n_fe++;
      if (tx_underrun) begin
        n_ur++;
        tot_ur++;
      end
      if (cs_hi_cnt >= 6) begin
        chk("idle_miso", 64'(miso), 64'(IDLE_LVL));
        chk("idle_miso_oe", 64'(miso_oe), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
      end
      if (cs_lo_cnt >= 6) begin
        chk("frame_busy", 64'(busy), 64'(mdl_live));
        chk("frame_miso_oe", 64'(miso_oe), 64'(mdl_live));
      end
    end
  end

  task automatic load_word(input logic [31:0] w);
    @(negedge clk_spi);
    tx_load = 1'b1;
    tx_data = w;
    @(negedge clk_spi);
    tx_load = 1'b0;
    mdl_shadow = w;
    mdl_loaded = 1'b1;
  endtask

  task automatic rst_pulse();
    #502;
    rst_n = 1'b0;
    mdl_live = 1'b0;
    mdl_shadow = '0;
    mdl_loaded = 1'b0;
    mdl_rx_hold = '0;
    #1;
    chk("rst_miso_oe", 64'(miso_oe), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_miso", 64'(miso), 64'(IDLE_LVL));
    #99;
    rst_n = 1'b1;
  endtask

  task automatic run_frame(input logic [31:0] mosi_w, input int nbits, input bit load_now,
                           input logic [31:0] load_w, input bit do_rst, output logic [31:0] got_w);
    logic [63:0] recv, got, exp;
    logic [31:0] exp_tx;
    bit          exp_ur;
    recv = '0;
    got  = '0;
    exp_ur = !(mdl_loaded || load_now);
    exp_tx = load_now ? load_w : mdl_shadow;
    if (load_now) mdl_shadow = load_w;
    mdl_loaded  = 1'b0;
    mdl_rx_word = mosi_w;
    n_rv = 0;
    n_fe = 0;
    n_ur = 0;
    mdl_live = 1'b1;
    @(negedge clk_spi);
    cs_n = 1'b0;
    mosi = mosi_w[31];
    if (load_now) begin
      tx_load = 1'b1;
      tx_data = load_w;
    end
    if (do_rst) fork rst_pulse(); join_none
    @(negedge clk_spi);
    tx_load = 1'b0;
    repeat (SC-1) @(negedge clk_spi);
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b1;
      recv = {recv[62:0], miso};
      repeat (SC) @(negedge clk_spi);
      sclk = 1'b0;
      mosi = (i < 31) ? mosi_w[30-i] : 1'b0;
      repeat (SC) @(negedge clk_spi);
    end
    cs_n = 1'b1;
    repeat (12) @(negedge clk_spi);
    if (!do_rst && nbits == FB) mdl_rx_hold = mosi_w;
    if (!do_rst) begin
      if (nbits >= FB) begin
        got = (recv >> (nbits - FB)) & 64'hFFFF_FFFF;
        exp = {32'd0, exp_tx};
      end else begin
        got = recv;
        exp = {32'd0, exp_tx} >> (FB - nbits);
      end
      chk("miso_word", got, exp);
    end
    chk("rx_valid_count", 64'(n_rv), 64'(!do_rst && nbits == FB));
    chk("frame_err_count", 64'(n_fe), 64'(!do_rst && nbits != FB));
    chk("underrun_count", 64'(n_ur), 64'(exp_ur));
    chk("rx_data_hold", 64'(rx_data), 64'(mdl_rx_hold));
    got_w = got[31:0];
  endtask

  logic [31:0] pats [4];
  logic [31:0] w;
  int          ur0;

  initial begin
    #3000000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0; tx_load = 1'b0; tx_data = '0;
    mdl_shadow = '0; mdl_loaded = 1'b0; mdl_rx_hold = '0; mdl_rx_word = '0; mdl_live = 1'b0;
    n_rv = 0; n_fe = 0; n_ur = 0; tot_ur = 0; cs_hi_cnt = 0; cs_lo_cnt = 0;
    pats = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hAA55_AA55, 32'h55AA_55AA};
    #1 rst_n = 1'b0;
    #20;
    chk("reset_miso", 64'(miso), 64'(IDLE_LVL));
    chk("reset_miso_oe", 64'(miso_oe), 64'd0);
    chk("reset_rx_data", 64'(rx_data), 64'd0);
    chk("reset_pulses", {61'd0, rx_valid, frame_err, tx_underrun}, 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk_spi);
    rst_n = 1'b1;
    repeat (8) @(negedge clk_spi);

    load_word(32'hDEADBEEF);
    run_frame(32'h0000_0001, FB, 1'b0, '0, 1'b0, w);
    chk("lit_deadbeef", 64'(w), 64'h0000_0000_DEAD_BEEF);

    ur0 = tot_ur;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        load_word(32'hA5A5_0000 + 32'(i));
        run_frame(32'(i), FB, 1'b0, '0, 1'b0, w);
      end else begin
        run_frame(32'(i), FB, 1'b1, 32'hA5A5_0000 + 32'(i), 1'b0, w);
      end
    end
    chk("lit_a5a5_last", 64'(w), 64'h0000_0000_A5A5_0013);
    chk("lit_rx_counter_last", 64'(rx_data), 64'd19);
    chk("lit_no_underrun_20", 64'(tot_ur - ur0), 64'd0);

    for (int p = 0; p < 4; p++) begin
      load_word(pats[p]);
      run_frame(~pats[p], FB, 1'b0, '0, 1'b0, w);
      chk("lit_pattern", 64'(w), 64'(pats[p]));
    end

    load_word(32'h1234_5678);
    run_frame(32'hCAFE_0000, FB, 1'b0, '0, 1'b0, w);
    ur0 = tot_ur;
    for (int k = 0; k < 3; k++) begin
      run_frame(32'hCAFE_0001 + 32'(k), FB, 1'b0, '0, 1'b0, w);
      chk("lit_resend", 64'(w), 64'h0000_0000_1234_5678);
    end
    chk("lit_underrun_3", 64'(tot_ur - ur0), 64'd3);

    // sclk activity while deselected must not disturb anything
    repeat (4) begin
      @(negedge clk_spi) sclk = 1'b1;
      repeat (2) @(negedge clk_spi);
      sclk = 1'b0;
    end

    load_word(32'h0BAD_0031);
    run_frame(32'h1111_1111, 31, 1'b0, '0, 1'b0, w);
    chk("lit_rx_after_short", 64'(rx_data), 64'h0000_0000_CAFE_0003);
    load_word(32'h0BAD_0033);
    run_frame(32'h2222_2222, 33, 1'b0, '0, 1'b0, w);
    chk("lit_rx_after_long", 64'(rx_data), 64'h0000_0000_CAFE_0003);
    load_word(32'h600D_F00D);
    run_frame(32'h3333_3333, FB, 1'b0, '0, 1'b0, w);
    chk("lit_after_err", 64'(w), 64'h0000_0000_600D_F00D);

    load_word(32'h1357_2468);
    run_frame(32'h4444_4444, FB, 1'b0, '0, 1'b1, w);
    load_word(32'h2468_ACE0);
    run_frame(32'h5555_5555, FB, 1'b0, '0, 1'b0, w);
    chk("lit_after_reset", 64'(w), 64'h0000_0000_2468_ACE0);
    chk("lit_rx_after_reset", 64'(rx_data), 64'h0000_0000_5555_5555);

    repeat (4) @(negedge clk_spi);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_slave_rhs2116.md
SPI_SLAVE_RHS2116 -- requirements
Module: spi_slave_rhs2116

Interface
REQ-001 The block SHALL have parameter FRAME_BITS, default 32, giving the number of SCLK cycles per valid frame.
REQ-002 The block SHALL have parameter IDLE_MISO, default 1'b0, giving the MISO level while cs_n is high.
REQ-003 The block SHALL have port clk_spi, input, 1 bit: the single clock, the same 64 MHz clock that drives the master.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port cs_n, input, 1 bit: chip select from the master, active low.
REQ-006 The block SHALL have port sclk, input, 1 bit: SPI clock from the master, idle low.
REQ-007 The block SHALL have port mosi, input, 1 bit: command bit from the master.
REQ-008 The block SHALL have port miso, output, 1 bit: response bit to the master, MSB first.
REQ-009 The block SHALL have port miso_oe, output, 1 bit: high while cs_n is low, for an external tristate.
REQ-010 The block SHALL have port tx_data, input, FRAME_BITS bits: the next response word.
REQ-011 The block SHALL have port tx_load, input, 1 bit: a one-cycle strobe that captures tx_data into the shadow register.
REQ-012 The block SHALL have port rx_data, output, FRAME_BITS bits: the last complete MOSI word.
REQ-013 The block SHALL have port rx_valid, output, 1 bit: a one-cycle pulse when rx_data updates.
REQ-014 The block SHALL have port frame_err, output, 1 bit: a one-cycle pulse on a short or long frame.
REQ-015 The block SHALL have port tx_underrun, output, 1 bit: a one-cycle pulse when a frame starts with no tx_load since the previous frame start.
REQ-016 The block SHALL have port busy, output, 1 bit: high while the FSM is in SHIFT.

Function
REQ-017 All inputs SHALL be treated as synchronous to clk_spi, registered once (cs_q, sclk_q, mosi_q); edges SHALL be detected from the registered value versus the current input.
REQ-018 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-019 IDLE->SHIFT SHALL occur on the detected cs_n fall: copy shadow to the shift register, clear the bit counter, and drive miso = shadow[FRAME_BITS-1] on the next cycle.
REQ-020 In SHIFT, on each detected sclk rise, the block SHALL shift mosi into rx_shift LSB-first-in (the first bit ends as the MSB) and increment the bit counter, which saturates at FRAME_BITS+1.
REQ-021 In SHIFT, on each detected sclk fall, the block SHALL shift the tx register left and update miso exactly 1 clk_spi cycle later, stable before the next sclk rise at 16 MHz.
REQ-022 SHIFT->DONE SHALL occur on the detected cs_n rise, and DONE->IDLE SHALL follow unconditionally after 1 cycle.
REQ-023 In DONE with count == FRAME_BITS, the block SHALL load rx_data and pulse rx_valid; otherwise it SHALL pulse frame_err and hold rx_data.
REQ-024 tx_load SHALL be accepted in any state; the shadow register changes only the next frame, never the frame in progress.
REQ-025 Simultaneous tx_load and cs_n fall SHALL make the new tx_data the current frame's response, with no underrun.
REQ-026 With no tx_load since the previous frame start, the block SHALL resend the previous shadow word and pulse tx_underrun in the IDLE->SHIFT cycle.
REQ-027 An sclk edge while cs_n is high SHALL be ignored.
REQ-028 A cs_n rise and an sclk edge in the same cycle SHALL resolve to the cs_n rise.
REQ-029 While cs_n is high, miso SHALL equal IDLE_MISO and miso_oe SHALL be 0.

Reset
REQ-030 On rst_n low, the block SHALL immediately set miso=IDLE_MISO, miso_oe=0, rx_data=0, rx_valid=0, frame_err=0, tx_underrun=0, busy=0, shadow=0, FSM=IDLE and the counter to 0.
REQ-031 A reset mid-frame SHALL discard the partial frame with no rx_valid or frame_err pulse.
REQ-032 After rst_n releases, the block SHALL wait for a fresh cs_n fall; if cs_n is already low, it SHALL stay in IDLE until cs_n goes high then low.

Configuration
REQ-033 When SPI_SLAVE_SYNC_EN is defined, cs_n, sclk and mosi SHALL pass through 2-flop synchronizers before edge detection, adding 2 cycles of latency to every edge and requiring clk_spi >= 8x SCLK.
REQ-034 Without SPI_SLAVE_SYNC_EN, the block SHALL use only the single input register of REQ-017 and SHALL operate at clk_spi = 4x SCLK.

Verification
REQ-035 Reset, then tx_load 32'hDEADBEEF, then run the master -> the master's data_out = DEADBEEF and rx_valid pulses once per frame.
REQ-036 Over 20 frames, tx_load 32'hA5A50000+i each frame while the master sends a MOSI counter -> every MISO word and every rx_data word match with no tx_underrun.
REQ-037 Patterns 00000000, FFFFFFFF, AA55AA55 and 55AA55AA back-to-back -> each is received exactly on the frame after it is loaded.
REQ-038 Stop tx_load for 3 frames after 12345678 -> 12345678 is resent 3 times and tx_underrun pulses 3 times.
REQ-039 A forced 31-SCLK frame and a 33-SCLK frame -> frame_err pulses for each, rx_data is unchanged and the next normal frame is correct.
REQ-040 Pulse rst_n low for 100 ns, 500 ns after a cs_n fall -> miso_oe=0 immediately, no rx_valid for that frame and a correct response on the next complete frame.
